hazard_fwd_unit: RTL

//  Producer of the EX-stage operand-forward selects and the pipeline stall.

---
 rtl/hazard_fwd_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EX operand-forward selects, load-use/flag stall, stall counter.
// Optional: define FLAG_HAZARD_EN to stall flag-conditional branches behind flag setters.
module hazard_fwd_unit #(
    parameter int NREG_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [NREG_W-1:0] id_rs,
    input  logic [NREG_W-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [NREG_W-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_flagset,
    input  logic              id_branch,
    input  logic              flush,
    output logic [1:0]        forward_aluin1,
    output logic [1:0]        forward_aluin2,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              valid;
        logic [NREG_W-1:0] rd;
        logic              regwrite;
        logic              memread;
    } prod_t;

    typedef struct packed {
        logic              valid;
        logic [NREG_W-1:0] rd;
        logic              regwrite;
    } wb_t;

    prod_t             ex_q;
    prod_t             mem_q;
    wb_t               wb_q;
    logic [NREG_W-1:0] ex_rs;
    logic [NREG_W-1:0] ex_rt;
    logic              ex_uses_rs;
    logic              ex_uses_rt;

    logic lu;
    logic flag_hz;
    logic advance;
    logic mem_fwd_ok;
    logic wb_fwd_ok;
    logic ex_use1;
    logic ex_use2;
    logic mem_hit1;
    logic mem_hit2;
    logic wb_hit1;
    logic wb_hit2;

`ifdef FLAG_HAZARD_EN
    logic ex_flagset;

    assign flag_hz = id_valid & id_branch & ex_q.valid & ex_flagset;
`else
    logic unused_flag_in;

    assign unused_flag_in = id_flagset ^ id_branch;
    assign flag_hz        = 1'b0;
`endif

    assign lu = id_valid & ex_q.valid & ex_q.memread
              & (ex_q.rd != '0)
              & ((id_uses_rs & (id_rs == ex_q.rd))
               | (id_uses_rt & (id_rt == ex_q.rd)));

    assign stall   = !flush & (lu | flag_hz);
    assign advance = id_valid & !stall & !flush;

    // A load in MEM has no data yet, so only WB may supply it.
    assign mem_fwd_ok = mem_q.valid & mem_q.regwrite
                      & !mem_q.memread & (mem_q.rd != '0);
    assign wb_fwd_ok  = wb_q.valid & wb_q.regwrite & (wb_q.rd != '0);

    assign ex_use1 = ex_q.valid & ex_uses_rs;
    assign ex_use2 = ex_q.valid & ex_uses_rt;

    assign mem_hit1 = ex_use1 & mem_fwd_ok & (mem_q.rd == ex_rs);
    assign mem_hit2 = ex_use2 & mem_fwd_ok & (mem_q.rd == ex_rt);
    assign wb_hit1  = ex_use1 & wb_fwd_ok & (wb_q.rd == ex_rs) & !mem_hit1;
    assign wb_hit2  = ex_use2 & wb_fwd_ok & (wb_q.rd == ex_rt) & !mem_hit2;

    always_comb begin
        forward_aluin1 = 2'b00;
        unique case (1'b1)
            mem_hit1: forward_aluin1 = 2'b01;
            wb_hit1:  forward_aluin1 = 2'b10;
            default:  forward_aluin1 = 2'b00;
        endcase
    end

    always_comb begin
        forward_aluin2 = 2'b00;
        unique case (1'b1)
            mem_hit2: forward_aluin2 = 2'b01;
            wb_hit2:  forward_aluin2 = 2'b10;
            default:  forward_aluin2 = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_uses_rs <= 1'b0;
            ex_uses_rt <= 1'b0;
`ifdef FLAG_HAZARD_EN
            ex_flagset <= 1'b0;
`endif
        end else begin
            wb_q.valid    <= mem_q.valid;
            wb_q.rd       <= mem_q.rd;
            wb_q.regwrite <= mem_q.regwrite;
            mem_q         <= ex_q;
            if (advance) begin
                ex_q.valid    <= 1'b1;
                ex_q.rd       <= id_rd;
                ex_q.regwrite <= id_regwrite;
                ex_q.memread  <= id_memread;
                ex_rs         <= id_rs;
                ex_rt         <= id_rt;
                ex_uses_rs    <= id_uses_rs;
                ex_uses_rt    <= id_uses_rt;
`ifdef FLAG_HAZARD_EN
                ex_flagset    <= id_flagset;
`endif
            end else begin
                ex_q.valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule
